// File: rtl/ahb_lite_rr_master_arbiter.sv
// AHB-Lite master front-end shared by NUM_REQ requesters.
// Round-robin grant per address phase, two-stage pipeline (address / data),
// wait-state and two-cycle ERROR handling, completion pulse back to the owner.
module ahb_lite_rr_master_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter int NUM_REQ   = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*3-1:0]          req_size,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          req_err,
  output logic [BUS_WIDTH-1:0]          req_rdata,
  output logic [BUS_WIDTH-1:0]          HADDR,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [3:0]                    HPROT,
  output logic [1:0]                    HTRANS,
  output logic                          HMASTLOCK,
  output logic [BUS_WIDTH-1:0]          HWDATA,
  input  logic                          HREADY,
  input  logic                          HRESP,
  input  logic [BUS_WIDTH-1:0]          HRDATA
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  logic [NUM_REQ-1:0]   busy;
  logic [NUM_REQ-1:0]   eligible;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     a_owner;
  logic [PTR_W-1:0]     d_owner;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     hi_idx;
  logic [PTR_W-1:0]     lo_idx;
  logic                 hi_found;
  logic                 lo_found;
  logic                 a_valid;
  logic                 d_valid;
  logic                 d_write;
  logic [BUS_WIDTH-1:0] a_wdata;
  logic                 slot_free;
  logic                 err_first;
  logic                 grant_en;
  logic                 d_complete;

  // The bus only ever issues single, non-locked, data/privileged transfers.
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign HTRANS    = a_valid ? TRANS_NONSEQ : TRANS_IDLE;

  assign eligible   = req_valid & ~busy;
  assign slot_free  = ~a_valid | HREADY;
  assign err_first  = d_valid & ~HREADY & HRESP;
  assign d_complete = d_valid & HREADY;
  assign grant_en   = slot_free & ~err_first & (|eligible);
  assign grant_idx  = hi_found ? hi_idx : lo_idx;

  // Round-robin pick: lowest eligible index at/above the pointer, else lowest overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_idx   = i[PTR_W-1:0];
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = i[PTR_W-1:0];
        end
      end
    end
  end

  // Address stage: first error cycle cancels it, otherwise load a new grant or go IDLE when free.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid <= 1'b0;
      a_owner <= '0;
      a_wdata <= '0;
      HADDR   <= '0;
      HWRITE  <= 1'b0;
      HSIZE   <= 3'b000;
    end else if (err_first) begin
      a_valid <= 1'b0;
    end else if (grant_en) begin
      a_valid <= 1'b1;
      a_owner <= grant_idx;
      a_wdata <= req_wdata[grant_idx*BUS_WIDTH +: BUS_WIDTH];
      HADDR   <= req_addr[grant_idx*BUS_WIDTH +: BUS_WIDTH];
      HWRITE  <= req_write[grant_idx];
      HSIZE   <= req_size[grant_idx*3 +: 3];
    end else if (slot_free) begin
      a_valid <= 1'b0;
    end
  end

  // Data stage advances with HREADY; HWDATA follows the write that enters the data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_valid <= 1'b0;
      d_owner <= '0;
      d_write <= 1'b0;
      HWDATA  <= '0;
    end else if (HREADY) begin
      d_valid <= a_valid;
      d_owner <= a_owner;
      d_write <= HWRITE;
      if (a_valid && HWRITE) begin
        HWDATA <= a_wdata;
      end
    end
  end

  // Pointer moves past whichever requester just had its address phase accepted.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rr_ptr <= '0;
    end else if (a_valid && HREADY) begin
      rr_ptr <= (a_owner == PTR_W'(NUM_REQ - 1)) ? '0 : a_owner + PTR_W'(1);
    end
  end

  // Busy tracks one outstanding transfer per requester from grant to completion or cancel.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      busy <= '0;
    end else begin
      if (d_complete) begin
        busy[d_owner] <= 1'b0;
      end
      if (err_first && a_valid) begin
        busy[a_owner] <= 1'b0;
      end
      if (grant_en) begin
        busy[grant_idx] <= 1'b1;
      end
    end
  end

  // One-cycle completion pulse to the owner with response status and read data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      req_done  <= '0;
      req_err   <= 1'b0;
      req_rdata <= '0;
    end else begin
      req_done  <= '0;
      req_err   <= 1'b0;
      req_rdata <= '0;
      if (d_complete) begin
        req_done  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << d_owner;
        req_err   <= HRESP;
        req_rdata <= d_write ? '0 : HRDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_rr_master_arbiter.sv
// Directed self-checking bench for ahb_lite_rr_master_arbiter (BUS_WIDTH=32, NUM_REQ=4).
module tb_ahb_lite_rr_master_arbiter;

  localparam int BW = 32;
  localparam int NR = 4;

  logic             HCLK;
  logic             HRESETn;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*BW-1:0] req_addr;
  logic [NR*BW-1:0] req_wdata;
  logic [NR*3-1:0]  req_size;
  logic [NR-1:0]    req_done;
  logic             req_err;
  logic [BW-1:0]    req_rdata;
  logic [BW-1:0]    HADDR;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [2:0]       HBURST;
  logic [3:0]       HPROT;
  logic [1:0]       HTRANS;
  logic             HMASTLOCK;
  logic [BW-1:0]    HWDATA;
  logic             HREADY;
  logic             HRESP;
  logic [BW-1:0]    HRDATA;

  int total;
  int bad;

  ahb_lite_rr_master_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(NR)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Raise one requester with its transfer fields.
  task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] size);
    req_write[idx]          = wr;
    req_addr[idx*BW +: BW]  = addr;
    req_wdata[idx*BW +: BW] = wdata;
    req_size[idx*3 +: 3]    = size;
    req_valid[idx]          = 1'b1;
  endtask

  // Advance one clock and land on the falling edge, where outputs are sampled.
  task automatic tick;
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  initial begin
    logic [1:0]  alt_trans [7];
    logic [31:0] alt_addr  [7];
    logic [3:0]  alt_done  [7];
    total     = 0;
    bad       = 0;
    HRESETn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = '0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge HCLK);
    checkOutput("rst_htrans", 32'(HTRANS), 32'h0);
    checkOutput("rst_haddr", HADDR, 32'h0);
    checkOutput("rst_hwdata", HWDATA, 32'h0);
    checkOutput("rst_hprot", 32'(HPROT), 32'h3);
    checkOutput("rst_hburst", 32'(HBURST), 32'h0);
    checkOutput("rst_hmastlock", 32'(HMASTLOCK), 32'h0);
    checkOutput("rst_done", 32'(req_done), 32'h0);
    HRESETn = 1'b1;
    tick();

    // ---------------- single write, requester 2 ----------------
    $display("[TB] single write req2");
    applyStimulus(2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010);
    tick();
    checkOutput("wr_htrans", 32'(HTRANS), 32'h2);
    checkOutput("wr_hwrite", 32'(HWRITE), 32'h1);
    checkOutput("wr_haddr", HADDR, 32'h0000_0010);
    checkOutput("wr_hsize", 32'(HSIZE), 32'h2);
    tick();
    checkOutput("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
    checkOutput("wr_idle", 32'(HTRANS), 32'h0);
    checkOutput("wr_nodone_early", 32'(req_done), 32'h0);
    tick();
    checkOutput("wr_done", 32'(req_done), 32'h4);
    checkOutput("wr_err", 32'(req_err), 32'h0);
    checkOutput("wr_rdata", req_rdata, 32'h0);
    req_valid[2] = 1'b0;
    tick();
    checkOutput("wr_done_pulse", 32'(req_done), 32'h0);

    // ---------------- read with two data-phase wait states, requester 0 ----------------
    $display("[TB] read req0 with wait states");
    applyStimulus(0, 1'b0, 32'h0000_0020, 32'h0, 3'b010);
    tick();
    checkOutput("rd_htrans", 32'(HTRANS), 32'h2);
    checkOutput("rd_hwrite", 32'(HWRITE), 32'h0);
    checkOutput("rd_haddr", HADDR, 32'h0000_0020);
    tick();
    HREADY = 1'b0;
    HRDATA = 32'hFFFF_0000;
    tick();
    checkOutput("rd_wait1", 32'(req_done), 32'h0);
    tick();
    checkOutput("rd_wait2", 32'(req_done), 32'h0);
    HREADY = 1'b1;
    HRDATA = 32'h1234_5678;
    tick();
    checkOutput("rd_done", 32'(req_done), 32'h1);
    checkOutput("rd_rdata", req_rdata, 32'h1234_5678);
    checkOutput("rd_err", 32'(req_err), 32'h0);
    req_valid[0] = 1'b0;
    HRDATA = 32'h0;

    // ---------------- all four from reset ----------------
    $display("[TB] four simultaneous requesters");
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    for (int i = 0; i < NR; i++) begin
      applyStimulus(i, 1'b1, 32'h0000_0100 + 32'(i * 4), 32'h0000_00A0 + 32'(i), 3'b010);
    end
    for (int t = 0; t < 6; t++) begin
      tick();
      if (t < 4) begin
        checkOutput($sformatf("all_htrans_%0d", t), 32'(HTRANS), 32'h2);
        checkOutput($sformatf("all_haddr_%0d", t), HADDR, 32'h0000_0100 + 32'(t * 4));
      end else if (t == 4) begin
        checkOutput("all_idle", 32'(HTRANS), 32'h0);
      end
      if (t >= 1 && t <= 4) begin
        checkOutput($sformatf("all_hwdata_%0d", t), HWDATA, 32'h0000_00A0 + 32'(t - 1));
      end
      if (t >= 2) begin
        checkOutput($sformatf("all_done_%0d", t), 32'(req_done), 32'h1 << (t - 2));
        req_valid[t-2] = 1'b0;
      end else begin
        checkOutput($sformatf("all_nodone_%0d", t), 32'(req_done), 32'h0);
      end
    end

    // ---------------- requesters 1 and 3 both keep requesting ----------------
    $display("[TB] alternation req1/req3");
    alt_trans = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
    alt_addr  = '{32'h200, 32'h300, 32'h0, 32'h200, 32'h300, 32'h0, 32'h0};
    alt_done  = '{4'h0, 4'h0, 4'h2, 4'h8, 4'h0, 4'h2, 4'h8};
    applyStimulus(1, 1'b0, 32'h0000_0200, 32'h0, 3'b010);
    applyStimulus(3, 1'b0, 32'h0000_0300, 32'h0, 3'b010);
    for (int t = 0; t < 7; t++) begin
      tick();
      checkOutput($sformatf("alt_htrans_%0d", t), 32'(HTRANS), 32'(alt_trans[t]));
      if (alt_trans[t] == 2'b10) begin
        checkOutput($sformatf("alt_haddr_%0d", t), HADDR, alt_addr[t]);
      end
      checkOutput($sformatf("alt_done_%0d", t), 32'(req_done), 32'(alt_done[t]));
      if (t == 5) req_valid[1] = 1'b0;
      if (t == 6) req_valid[3] = 1'b0;
    end

    // ---------------- ERROR on req0 while req1 waits in address phase ----------------
    $display("[TB] error response with pending address phase");
    applyStimulus(0, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 3'b010);
    applyStimulus(1, 1'b0, 32'h0000_0044, 32'h0, 3'b010);
    tick();
    checkOutput("err_g0_haddr", HADDR, 32'h0000_0040);
    tick();
    checkOutput("err_g1_haddr", HADDR, 32'h0000_0044);
    checkOutput("err_g1_htrans", 32'(HTRANS), 32'h2);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    tick();
    checkOutput("err_cycle1_idle", 32'(HTRANS), 32'h0);
    checkOutput("err_cycle1_nodone", 32'(req_done), 32'h0);
    HREADY = 1'b1;
    tick();
    checkOutput("err_done0", 32'(req_done), 32'h1);
    checkOutput("err_flag", 32'(req_err), 32'h1);
    checkOutput("err_reissue_htrans", 32'(HTRANS), 32'h2);
    checkOutput("err_reissue_haddr", HADDR, 32'h0000_0044);
    req_valid[0] = 1'b0;
    HRESP  = 1'b0;
    HRDATA = 32'hCAFE_F00D;
    tick();
    checkOutput("err_r1_nodone", 32'(req_done), 32'h0);
    tick();
    checkOutput("err_r1_done", 32'(req_done), 32'h2);
    checkOutput("err_r1_ok", 32'(req_err), 32'h0);
    checkOutput("err_r1_rdata", req_rdata, 32'hCAFE_F00D);
    req_valid[1] = 1'b0;
    HRDATA = 32'h0;

    // ---------------- reset during an active data phase ----------------
    $display("[TB] reset mid-transfer");
    applyStimulus(3, 1'b1, 32'h0000_0330, 32'h3333_3333, 3'b010);
    applyStimulus(1, 1'b1, 32'h0000_0110, 32'h1111_1111, 3'b010);
    tick();
    checkOutput("rst_mid_g3", HADDR, 32'h0000_0330);
    tick();
    checkOutput("rst_mid_g1", HADDR, 32'h0000_0110);
    checkOutput("rst_mid_busy", 32'(HTRANS), 32'h2);
    HREADY = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("rst_mid_htrans", 32'(HTRANS), 32'h0);
    checkOutput("rst_mid_haddr", HADDR, 32'h0);
    checkOutput("rst_mid_done", 32'(req_done), 32'h0);
    @(negedge HCLK);
    HREADY = 1'b1;
    applyStimulus(0, 1'b1, 32'h0000_0000 + 32'h80, 32'h0, 3'b010);
    tick();
    checkOutput("rst_hold_htrans", 32'(HTRANS), 32'h0);
    HRESETn = 1'b1;
    tick();
    checkOutput("post_rst_htrans", 32'(HTRANS), 32'h2);
    checkOutput("post_rst_g0", HADDR, 32'h0000_0080);
    checkOutput("post_rst_nodone", 32'(req_done), 32'h0);
    tick();
    checkOutput("post_rst_g1", HADDR, 32'h0000_0110);
    checkOutput("post_rst_nodone2", 32'(req_done), 32'h0);
    tick();
    checkOutput("post_rst_done0", 32'(req_done), 32'h1);
    req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_rr_master_arbiter.md
Name: ahb_lite_rr_master_arbiter

Overview:
Shares the single AHB-Lite master port between NUM_REQ internal requesters, each issuing single (non-burst) read/write transfers. Round-robin arbitration selects one requester per address phase. The block runs the two-stage AHB-Lite pipeline (address phase overlapping the previous data phase), absorbs HREADY wait states and the two-cycle HRESP error response, and returns read data and status to the owning requester.

Parameters:
BUS_WIDTH, 32, width of address and data buses
NUM_REQ, 4, number of requesters (2..8)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request, held high until its req_done
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*BUS_WIDTH  packed addresses, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
req_wdata  in  NUM_REQ*BUS_WIDTH  packed write data
req_size  in  NUM_REQ*3  packed HSIZE values
req_done  out  NUM_REQ  one-cycle completion pulse, one-hot
req_err  out  1  valid with req_done: 1 = ERROR response
req_rdata  out  BUS_WIDTH  read data, valid with req_done on a read
HADDR  out  BUS_WIDTH  address
HWRITE  out  1  direction
HSIZE  out  3  size
HBURST  out  3  always SINGLE (3'b000)
HPROT  out  4  always 4'b0011
HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only
HMASTLOCK  out  1  always 0
HWDATA  out  BUS_WIDTH  write data of the transfer in data phase
HREADY  in  1  transfer ready
HRESP  in  1  0 = OKAY, 1 = ERROR
HRDATA  in  BUS_WIDTH  read data

Behaviour:
- Reset (async, HRESETn low): HTRANS=IDLE; HADDR, HWDATA, HSIZE, HWRITE, req_done, req_err, req_rdata = 0; HBURST=0, HPROT=4'b0011, HMASTLOCK=0; both pipeline stages empty; RR pointer set so requester 0 has top priority.
- Eligible = req_valid & ~busy. busy[i] is set from grant until req_done[i], or until the transfer is cancelled. At most one outstanding transfer per requester.
- Address slot free = address stage empty, or address stage holding NONSEQ with HREADY high.
- On a rising edge with the slot free and any requester eligible, grant the first eligible requester at or after the pointer, scanning upward with wrap from NUM_REQ-1 to 0.
  - Register its addr/write/size onto the H* outputs with HTRANS=NONSEQ.
  - Capture its wdata into the address stage.
  - Slot free but nothing eligible -> HTRANS=IDLE; other address outputs hold their values.
- Pointer = accepted_index+1 (mod NUM_REQ), updated only when an address phase is accepted (HREADY high at the edge).
- Edge with HREADY high: address stage moves to data stage; HWDATA takes the captured wdata for writes.
- Data stage completes at an edge with HREADY high. The next cycle asserts req_done[owner] for exactly 1 cycle, with:
  - req_err = HRESP;
  - req_rdata = HRDATA sampled at that edge for reads, 0 for writes.
- HREADY low with HRESP low: all stages and outputs hold.
- Error, first cycle (edge sees HREADY low, HRESP high):
  - next cycle HTRANS=IDLE;
  - any pending address-stage transfer is cancelled: no done pulse, its busy bit cleared, it re-arbitrates normally;
  - no new grant that cycle.
- Error, second cycle (HREADY high, HRESP high): data phase completes with req_err=1.
- Latency with zero wait states: req_valid seen at edge E0 -> NONSEQ after E0 -> data phase after E1 -> req_done after E2 (3 cycles). Each wait state adds 1 cycle. Throughput is 1 transfer per cycle across different requesters.
- A requester whose req_valid drops while busy is a protocol violation. The transfer still completes on the captured fields.
- Reset asserted mid-transfer aborts silently, with no done pulse.

Test Plan:
- Single write, req 2, addr 0x0000_0010, data 0xDEAD_BEEF, size 3'b010, HREADY=1 -> NONSEQ/HWRITE=1 1 cycle after req; HWDATA=0xDEAD_BEEF the following cycle; req_done=4'b0100, req_err=0 3 cycles after req.
- Single read, req 0, HRDATA=0x1234_5678, 2 wait states in data phase -> req_done[0] 5 cycles after req; req_rdata=0x1234_5678.
- All 4 requesters valid simultaneously from reset, HREADY=1 -> NONSEQ on 4 consecutive cycles with grant order 0,1,2,3; done pulses on 4 consecutive cycles, same order.
- Req 1 continuously re-requesting while req 3 is valid -> grants alternate 1,3,1,3; no requester starves.
- Req 0 in data phase gets ERROR (HREADY=0/HRESP=1, then 1/1) while req 1 is in address phase -> HTRANS=IDLE for the cycle after the first error cycle; req_done[0] with req_err=1; req 1 re-issued NONSEQ and later completes OKAY.
- HRESETn pulsed low during an active data phase -> HTRANS=IDLE immediately; no req_done; after release, req 0 wins the next grant.
